matrix_loader: RTL and testbench
================================

# matrix_loader

Streaming front-end for the M x N * N x P bfloat16 matrix-multiply path. It accepts operand words over a valid/ready stream and assembles them into register arrays: matrix A row-major, then matrix B row-major. It presents both matrices as parallel arrays to the skewing stage directly downstream. It holds that stage in reset through `oLaunch_n` until a complete frame is resident, which releases it to start its skew sequence.

## Interface
- `BW`, 16, word width (bfloat16, opaque bits; no arithmetic performed)
- `M`, 3, rows of A
- `N`, 4, columns of A = rows of B
- `P`, 5, columns of B
- `clk`  in  1  clock, all state updates on posedge
- `rst_n`  in  1  reset; synchronous, active-low (sampled on posedge clk only)
- `iValid`  in  1  upstream word valid
- `iData`  in  BW  upstream word
- `oReady`  out  1  loader can accept a word this cycle
- `iRelease`  in  1  consumer done with current frame; honoured only in DONE
- `oRow`  out  BW x [M][N]  matrix A, `oRow[r][c]`
- `oCol`  out  BW x [N][P]  matrix B, `oCol[r][c]`
- `oLaunch_n`  out  1  active-low reset for the downstream stage; 1 = frame resident
- `iLast`, `oErr`: present only with `MATRIX_LOADER_LAST_CHECK_EN` (see Configuration)

## Operation
- Transfer occurs on a posedge where `iValid && oReady`. No other condition writes the arrays.
- FSM states are IDLE, LOAD_A, LOAD_B, DONE.
  - IDLE: reset state. Moves unconditionally to LOAD_A on the next edge.
  - LOAD_A: counters `ra` (0..M-1) and `ca` (0..N-1). Each transfer writes `oRow[ra][ca]`, then increments `ca`, wrapping to 0 and incrementing `ra`. The transfer of word M*N-1 (ra=M-1, ca=N-1) moves to LOAD_B with counters zeroed.
  - LOAD_B: counters `rb` (0..N-1) and `cb` (0..P-1), same order, writing `oCol[rb][cb]`. The transfer of word N*P-1 moves to DONE.
  - DONE: no transfers. `iRelease=1` moves to LOAD_A with all counters zeroed.
- Counters are nested row/column counters. Each is `$clog2` of its bound, minimum 1 bit. No division or modulo.
- `oReady` = state is LOAD_A or LOAD_B (registered-state decode).
- `oLaunch_n` is registered and equals 1 exactly while state is DONE.
- Array contents persist across frames and are overwritten entry by entry during the next load. They are never cleared except by reset.
- `iRelease` in IDLE, LOAD_A or LOAD_B is ignored. `iValid` with `oReady=0` is ignored; the upstream must hold the word.
- `rst_n=0` mid-load aborts the frame. All state returns to reset values on that edge. No partial frame is ever launched.

## Timing
- Reset values: state IDLE, all counters 0, all `oRow`/`oCol` entries 0, `oReady` 0, `oLaunch_n` 0, `oErr` 0.
- First edge with `rst_n=1`: IDLE→LOAD_A, so `oReady`=1 from the following cycle.
- Throughput: one word per cycle. The minimum frame is M*N + N*P cycles of accepted data (32 at defaults).
- Final B word accepted at edge t: `oLaunch_n`=1 and `oReady`=0 in cycle t+1. The arrays are stable from t+1 until release.
- `iRelease` sampled high in DONE at edge u: `oLaunch_n`=0 and `oReady`=1 in cycle u+1. The first word of the next frame can be accepted at edge u+1.
- Combinational paths: none from `iValid`/`iData` to any output.

## Configuration
- `MATRIX_LOADER_LAST_CHECK_EN` defined:
  - Adds input `iLast` (1 bit, sampled with each transfer) and output `oErr` (1 bit, registered, reset 0).
  - `iLast` must be 1 on exactly the final B word of a frame.
  - Violation when `iLast=1` on any other word, or `iLast=0` on the final B word. On a violation the frame is discarded: next state is LOAD_A with counters zeroed, DONE is not entered, and `oLaunch_n` stays 0.
  - `oErr` pulses high for exactly one cycle, the cycle after the offending transfer. The offending word is still written to the arrays.
- Macro undefined: ports `iLast`/`oErr` do not exist. Frame boundaries are determined by counters alone.

## Test plan
- Reset, then stream 1..32 with `iValid` held 1 → `oReady` high for 32 cycles; `oRow[0][0]`=1, `oRow[2][3]`=12, `oCol[0][0]`=13, `oCol[3][4]`=32; `oLaunch_n` rises one cycle after word 32.
- Same frame with `iValid` toggled every other cycle → identical array contents; `oLaunch_n` rises one cycle after the 32nd accepted word.
- In DONE, drive `iValid=1` with data 0xFFFF for 5 cycles, then `iRelease=1` → arrays unchanged before release; `oLaunch_n`=0 and `oReady`=1 the cycle after release.
- Assert `rst_n=0` after 20 accepted words, then reload 101..132 → all outputs 0 during reset; the final frame contains only 101..132, launched once.
- `iRelease` pulsed during LOAD_A at word 5 → no effect; frame completes normally at word 32.
- With `MATRIX_LOADER_LAST_CHECK_EN`:
  - `iLast=1` on word 10 → `oErr`=1 for one cycle after word 10, no launch, and the next word loads `oRow[0][0]`.
  - A correct frame with `iLast` on word 32 → launch and `oErr`=0.

Source files
------------

// File: rtl/matrix_loader.sv
// -----------------------------------------------------------------------------
// matrix_loader
//
// Streaming front-end for the M x N * N x P bfloat16 matrix-multiply path.
// Words arrive over a valid/ready stream. They fill matrix A (row-major)
// first, then matrix B (row-major). Both matrices are presented as parallel
// arrays to the downstream skewing stage. That stage is held in reset through
// oLaunch_n until a complete frame is resident. Word contents are opaque bits.
//
// Optional feature: define MATRIX_LOADER_LAST_CHECK_EN to add the iLast/oErr
// frame-boundary check. With it undefined, only the counters delimit a frame.
//
// Ports:
//   clk        clock, all state updates on posedge
//   rst_n      synchronous active-low reset
//   iValid     upstream word valid
//   iData      upstream word (BW bits)
//   oReady     loader accepts a word this cycle (state is LOAD_A or LOAD_B)
//   iRelease   consumer done with current frame; honoured only in DONE
//   oRow       matrix A, oRow[r][c], M x N words
//   oCol       matrix B, oCol[r][c], N x P words
//   oLaunch_n  active-low reset for the downstream stage; 1 = frame resident
//   iLast      (LAST_CHECK only) marks the final B word of a frame
//   oErr       (LAST_CHECK only) one-cycle pulse after a misplaced iLast
// -----------------------------------------------------------------------------
module matrix_loader #(
  parameter int BW = 16,
  parameter int M  = 3,
  parameter int N  = 4,
  parameter int P  = 5
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          iValid,
  input  logic [BW-1:0]                 iData,
  output logic                          oReady,
  input  logic                          iRelease,
  output logic [M-1:0][N-1:0][BW-1:0]   oRow,
  output logic [N-1:0][P-1:0][BW-1:0]   oCol,
  output logic                          oLaunch_n
`ifdef MATRIX_LOADER_LAST_CHECK_EN
  ,
  input  logic                          iLast,
  output logic                          oErr
`endif
);

  localparam int RAW = (M > 1) ? $clog2(M) : 1;
  localparam int CAW = (N > 1) ? $clog2(N) : 1;
  localparam int RBW = (N > 1) ? $clog2(N) : 1;
  localparam int CBW = (P > 1) ? $clog2(P) : 1;

  typedef enum logic [1:0] {IDLE, LOAD_A, LOAD_B, DONE} stateT;

  stateT          state;
  logic [RAW-1:0] ra;
  logic [CAW-1:0] ca;
  logic [RBW-1:0] rb;
  logic [CBW-1:0] cb;

  logic transfer;
  logic caWrap;
  logic raWrap;
  logic cbWrap;
  logic rbWrap;
  logic lastErr;

  // oReady is a registered copy of the state decode, so the handshake never
  // depends combinationally on iValid or iData.
  // NOTE: every signal driven in always_comb gets a value on every path (here
  // by plain assignment), otherwise synthesis infers a latch.
  always_comb begin
    transfer = iValid && oReady;
    caWrap   = (ca == CAW'(N - 1));
    raWrap   = (ra == RAW'(M - 1));
    cbWrap   = (cb == CBW'(P - 1));
    rbWrap   = (rb == RBW'(N - 1));
`ifdef MATRIX_LOADER_LAST_CHECK_EN
    // iLast must be high on the final B word and nowhere else.
    lastErr  = (state == LOAD_B && rbWrap && cbWrap) ? !iLast : iLast;
`else
    lastErr  = 1'b0;
`endif
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register in this block samples the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      ra        <= '0;
      ca        <= '0;
      rb        <= '0;
      cb        <= '0;
      oReady    <= 1'b0;
      oLaunch_n <= 1'b0;
      // NOTE: the operand arrays are reset as well. Downstream observes them
      // directly, so they must read 0 after reset rather than stale data.
      oRow      <= '0;
      oCol      <= '0;
`ifdef MATRIX_LOADER_LAST_CHECK_EN
      oErr      <= 1'b0;
`endif
    end else begin
`ifdef MATRIX_LOADER_LAST_CHECK_EN
      // A transfer only happens in a load state, so this pulses for exactly
      // the cycle after an offending word.
      oErr <= transfer && lastErr;
`endif
      case (state)
        IDLE: begin
          state  <= LOAD_A;
          oReady <= 1'b1;
        end

        LOAD_A: begin
          if (transfer) begin
            oRow[ra][ca] <= iData;
            if (lastErr) begin
              ra <= '0;
              ca <= '0;
            end else if (caWrap) begin
              ca <= '0;
              if (raWrap) begin
                ra    <= '0;
                state <= LOAD_B;
              end else begin
                ra <= ra + RAW'(1);
              end
            end else begin
              ca <= ca + CAW'(1);
            end
          end
        end

        LOAD_B: begin
          if (transfer) begin
            oCol[rb][cb] <= iData;
            if (lastErr) begin
              // Discard the frame: restart A. The A counters are already 0.
              rb    <= '0;
              cb    <= '0;
              state <= LOAD_A;
            end else if (cbWrap) begin
              cb <= '0;
              if (rbWrap) begin
                rb        <= '0;
                state     <= DONE;
                oReady    <= 1'b0;
                oLaunch_n <= 1'b1;
              end else begin
                rb <= rb + RBW'(1);
              end
            end else begin
              cb <= cb + CBW'(1);
            end
          end
        end

        DONE: begin
          if (iRelease) begin
            ra        <= '0;
            ca        <= '0;
            rb        <= '0;
            cb        <= '0;
            state     <= LOAD_A;
            oReady    <= 1'b1;
            oLaunch_n <= 1'b0;
          end
        end

        default: begin
          state     <= IDLE;
          oReady    <= 1'b0;
          oLaunch_n <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_matrix_loader.sv
// -----------------------------------------------------------------------------
// tb_matrix_loader
//
// Directed self-checking bench for matrix_loader at default sizes (3x4 * 4x5).
// Inputs are driven and outputs are sampled on the falling clock edge.
// Expected array contents come from a row-major fill model of the frame data.
// -----------------------------------------------------------------------------
module tb_matrix_loader;

  localparam int BW = 16;
  localparam int M  = 3;
  localparam int N  = 4;
  localparam int P  = 5;
  localparam int FRAME = M * N + N * P;

  logic                        clk;
  logic                        rst_n;
  logic                        iValid;
  logic [BW-1:0]               iData;
  logic                        oReady;
  logic                        iRelease;
  logic [M-1:0][N-1:0][BW-1:0] oRow;
  logic [N-1:0][P-1:0][BW-1:0] oCol;
  logic                        oLaunch_n;
  logic                        iLast;
`ifdef MATRIX_LOADER_LAST_CHECK_EN
  logic                        oErr;
`endif

  logic [M-1:0][N-1:0][BW-1:0] expRow;
  logic [N-1:0][P-1:0][BW-1:0] expCol;

  int tests = 0;
  int fails = 0;

  matrix_loader #(.BW(BW), .M(M), .N(N), .P(P)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .iValid    (iValid),
    .iData     (iData),
    .oReady    (oReady),
    .iRelease  (iRelease),
    .oRow      (oRow),
    .oCol      (oCol),
    .oLaunch_n (oLaunch_n)
`ifdef MATRIX_LOADER_LAST_CHECK_EN
    ,
    .iLast     (iLast),
    .oErr      (oErr)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Frame word k (0-based) carries base+k+1: A row-major, then B row-major.
  function automatic void fillExp(input int base);
    for (int r = 0; r < M; r++)
      for (int c = 0; c < N; c++)
        expRow[r][c] = 16'(base + r * N + c + 1);
    for (int r = 0; r < N; r++)
      for (int c = 0; c < P; c++)
        expCol[r][c] = 16'(base + M * N + r * P + c + 1);
  endfunction

  // Offers one word and returns after the posedge that accepts it.
  task automatic send(input logic [BW-1:0] d, input logic last, input logic rel,
                      output int waited, output logic launchSeen);
    waited = 0;
    @(negedge clk);
    iValid = 1'b1; iData = d; iLast = last; iRelease = rel;
    while (oReady !== 1'b1 && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    launchSeen = oLaunch_n;
    if (oReady !== 1'b1) begin
      tests++; fails++;
      $display("FAIL send_timeout word=%0d oReady=%b required=1", d, oReady);
    end
    @(posedge clk);
  endtask

  // Streams a full frame; iLast marks the final word, iRelease pulses at relAt.
  task automatic streamFrame(input int base, input bit gap, input int relAt,
                             output int stalls, output logic sawLaunch);
    int   w;
    logic l;
    stalls = 0; sawLaunch = 1'b0;
    for (int i = 0; i < FRAME; i++) begin
      send(16'(base + i + 1), i == FRAME - 1, i == relAt, w, l);
      stalls += w;
      sawLaunch |= l;
      if (gap && i != FRAME - 1) begin
        @(negedge clk);
        iValid = 1'b0; iRelease = 1'b0;
      end
    end
    @(negedge clk);
    iValid = 1'b0; iLast = 1'b0; iRelease = 1'b0;
  endtask

  task automatic doRelease();
    @(negedge clk);
    iValid = 1'b0; iRelease = 1'b1;
    @(negedge clk);
    iRelease = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; iValid = 1'b0; iData = '0; iRelease = 1'b0; iLast = 1'b0;
    repeat (2) @(negedge clk);
    tests++; if (oReady !== 1'b0) begin fails++; $display("FAIL reset_ready got=%b exp=0", oReady); end
    tests++; if (oLaunch_n !== 1'b0) begin fails++; $display("FAIL reset_launch got=%b exp=0", oLaunch_n); end
    tests++; if (oRow !== '0 || oCol !== '0) begin fails++; $display("FAIL reset_arrays row=%h col=%h exp=0", oRow, oCol); end
`ifdef MATRIX_LOADER_LAST_CHECK_EN
    tests++; if (oErr !== 1'b0) begin fails++; $display("FAIL reset_err got=%b exp=0", oErr); end
`endif
    rst_n = 1'b1;
    @(negedge clk);
    tests++; if (oReady !== 1'b1) begin fails++; $display("FAIL reset_exit_ready got=%b exp=1", oReady); end
  endtask

  task automatic test_stream();
    int   stalls;
    logic early;
    fillExp(0);
    streamFrame(0, 1'b0, -1, stalls, early);
    tests++; if (stalls != 0) begin fails++; $display("FAIL stream_ready stalls=%0d exp=0", stalls); end
    tests++; if (early !== 1'b0) begin fails++; $display("FAIL stream_early_launch got=%b exp=0", early); end
    tests++; if (oLaunch_n !== 1'b1) begin fails++; $display("FAIL stream_launch got=%b exp=1", oLaunch_n); end
    tests++; if (oReady !== 1'b0) begin fails++; $display("FAIL stream_ready_done got=%b exp=0", oReady); end
    tests++; if (oRow[0][0] !== 16'd1) begin fails++; $display("FAIL stream_row00 got=%0d exp=1", oRow[0][0]); end
    tests++; if (oRow[2][3] !== 16'd12) begin fails++; $display("FAIL stream_row23 got=%0d exp=12", oRow[2][3]); end
    tests++; if (oCol[0][0] !== 16'd13) begin fails++; $display("FAIL stream_col00 got=%0d exp=13", oCol[0][0]); end
    tests++; if (oCol[3][4] !== 16'd32) begin fails++; $display("FAIL stream_col34 got=%0d exp=32", oCol[3][4]); end
    tests++; if (oRow !== expRow) begin fails++; $display("FAIL stream_rows got=%h exp=%h", oRow, expRow); end
    tests++; if (oCol !== expCol) begin fails++; $display("FAIL stream_cols got=%h exp=%h", oCol, expCol); end
  endtask

  // Expects DONE on entry with the base-0 frame resident.
  task automatic test_done_hold();
    @(negedge clk);
    iValid = 1'b1; iData = 16'hFFFF;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      tests++;
      if (oReady !== 1'b0 || oLaunch_n !== 1'b1) begin
        fails++; $display("FAIL done_hold cycle=%0d ready=%b launch=%b exp ready=0 launch=1", i, oReady, oLaunch_n);
      end
    end
    tests++; if (oRow !== expRow || oCol !== expCol) begin fails++; $display("FAIL done_hold_arrays row=%h col=%h", oRow, oCol); end
    iValid = 1'b0; iRelease = 1'b1;
    @(negedge clk);
    iRelease = 1'b0;
    tests++; if (oLaunch_n !== 1'b0) begin fails++; $display("FAIL release_launch got=%b exp=0", oLaunch_n); end
    tests++; if (oReady !== 1'b1) begin fails++; $display("FAIL release_ready got=%b exp=1", oReady); end
    tests++; if (oRow !== expRow || oCol !== expCol) begin fails++; $display("FAIL release_arrays row=%h col=%h", oRow, oCol); end
  endtask

  // Expects LOAD_A on entry.
  task automatic test_release_ignored();
    int   stalls;
    logic early;
    fillExp(40);
    streamFrame(40, 1'b0, 4, stalls, early);
    tests++; if (early !== 1'b0) begin fails++; $display("FAIL relign_early_launch got=%b exp=0", early); end
    tests++; if (oLaunch_n !== 1'b1) begin fails++; $display("FAIL relign_launch got=%b exp=1", oLaunch_n); end
    tests++; if (oRow !== expRow) begin fails++; $display("FAIL relign_rows got=%h exp=%h", oRow, expRow); end
    tests++; if (oCol !== expCol) begin fails++; $display("FAIL relign_cols got=%h exp=%h", oCol, expCol); end
  endtask

  task automatic test_toggle();
    int   stalls;
    logic early;
    test_reset();
    fillExp(0);
    streamFrame(0, 1'b1, -1, stalls, early);
    tests++; if (stalls != 0) begin fails++; $display("FAIL toggle_stalls got=%0d exp=0", stalls); end
    tests++; if (early !== 1'b0) begin fails++; $display("FAIL toggle_early_launch got=%b exp=0", early); end
    tests++; if (oLaunch_n !== 1'b1) begin fails++; $display("FAIL toggle_launch got=%b exp=1", oLaunch_n); end
    tests++; if (oRow !== expRow) begin fails++; $display("FAIL toggle_rows got=%h exp=%h", oRow, expRow); end
    tests++; if (oCol !== expCol) begin fails++; $display("FAIL toggle_cols got=%h exp=%h", oCol, expCol); end
  endtask

  task automatic test_abort();
    int   w;
    logic l;
    int   stalls;
    logic early;
    doRelease();
    for (int i = 0; i < 20; i++) send(16'(80 + i + 1), 1'b0, 1'b0, w, l);
    @(negedge clk);
    iValid = 1'b0; rst_n = 1'b0;
    @(negedge clk);
    tests++; if (oReady !== 1'b0 || oLaunch_n !== 1'b0) begin fails++; $display("FAIL abort_ctrl ready=%b launch=%b exp 0 0", oReady, oLaunch_n); end
    tests++; if (oRow !== '0 || oCol !== '0) begin fails++; $display("FAIL abort_arrays row=%h col=%h exp=0", oRow, oCol); end
    rst_n = 1'b1;
    fillExp(100);
    streamFrame(100, 1'b0, -1, stalls, early);
    tests++; if (early !== 1'b0) begin fails++; $display("FAIL abort_early_launch got=%b exp=0", early); end
    tests++; if (oRow !== expRow) begin fails++; $display("FAIL abort_rows got=%h exp=%h", oRow, expRow); end
    tests++; if (oCol !== expCol) begin fails++; $display("FAIL abort_cols got=%h exp=%h", oCol, expCol); end
    for (int i = 0; i < 3; i++) begin
      tests++;
      if (oLaunch_n !== 1'b1) begin fails++; $display("FAIL abort_launch cycle=%0d got=%b exp=1", i, oLaunch_n); end
      @(negedge clk);
    end
  endtask

`ifdef MATRIX_LOADER_LAST_CHECK_EN
  task automatic test_last_check();
    int   w;
    logic l;
    int   stalls;
    logic early;
    doRelease();
    for (int i = 0; i < 10; i++) send(16'(i + 1), i == 9, 1'b0, w, l);
    @(negedge clk);
    iValid = 1'b0; iLast = 1'b0;
    tests++; if (oErr !== 1'b1) begin fails++; $display("FAIL lastchk_err got=%b exp=1", oErr); end
    tests++; if (oLaunch_n !== 1'b0 || oReady !== 1'b1) begin fails++; $display("FAIL lastchk_ctrl launch=%b ready=%b exp 0 1", oLaunch_n, oReady); end
    tests++; if (oRow[2][1] !== 16'd10) begin fails++; $display("FAIL lastchk_written got=%0d exp=10", oRow[2][1]); end
    @(negedge clk);
    tests++; if (oErr !== 1'b0) begin fails++; $display("FAIL lastchk_err_pulse got=%b exp=0", oErr); end
    fillExp(300);
    streamFrame(300, 1'b0, -1, stalls, early);
    tests++; if (early !== 1'b0) begin fails++; $display("FAIL lastchk_early_launch got=%b exp=0", early); end
    tests++; if (oLaunch_n !== 1'b1 || oErr !== 1'b0) begin fails++; $display("FAIL lastchk_good launch=%b err=%b exp 1 0", oLaunch_n, oErr); end
    tests++; if (oRow[0][0] !== 16'd301) begin fails++; $display("FAIL lastchk_restart got=%0d exp=301", oRow[0][0]); end
    tests++; if (oRow !== expRow || oCol !== expCol) begin fails++; $display("FAIL lastchk_arrays row=%h col=%h", oRow, oCol); end
  endtask
`endif

  initial begin
    test_reset();
    test_stream();
    test_done_hold();
    test_release_ignored();
    test_toggle();
    test_abort();
`ifdef MATRIX_LOADER_LAST_CHECK_EN
    test_last_check();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
